// File: rtl/fir_axi_filter.sv
// 11-tap signed FIR accelerator: AXI4-Lite control/tap port, AXI4-Stream in/out,
// coefficients and a circular sample history kept in two external registered-read RAMs.
module fir_axi_filter #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst,
   // AXI4-Lite write
   input  logic                   awvalid,
   output logic                   awready,
   input  logic [pADDR_WIDTH-1:0] awaddr,
   input  logic                   wvalid,
   output logic                   wready,
   input  logic [pDATA_WIDTH-1:0] wdata,
   // AXI4-Lite read
   input  logic                   arvalid,
   output logic                   arready,
   input  logic [pADDR_WIDTH-1:0] araddr,
   output logic                   rvalid,
   input  logic                   rready,
   output logic [pDATA_WIDTH-1:0] rdata,
   // AXI4-Stream in
   input  logic                   ss_tvalid,
   output logic                   ss_tready,
   input  logic [pDATA_WIDTH-1:0] ss_tdata,
   input  logic                   ss_tlast,
   // AXI4-Stream out
   output logic                   sm_tvalid,
   input  logic                   sm_tready,
   output logic [pDATA_WIDTH-1:0] sm_tdata,
   output logic                   sm_tlast,
   // tap RAM
   output logic [3:0]             tap_WE,
   output logic                   tap_EN,
   output logic [pDATA_WIDTH-1:0] tap_Di,
   output logic [pADDR_WIDTH-1:0] tap_A,
   input  logic [pDATA_WIDTH-1:0] tap_Do,
   // data RAM
   output logic [3:0]             data_WE,
   output logic                   data_EN,
   output logic [pDATA_WIDTH-1:0] data_Di,
   output logic [pADDR_WIDTH-1:0] data_A,
   input  logic [pDATA_WIDTH-1:0] data_Do
);

   localparam int AW = pADDR_WIDTH;
   localparam int DW = pDATA_WIDTH;
   localparam logic [3:0] LAST_IDX = 4'(Tape_Num - 1);
   localparam logic [3:0] MAC_END  = 4'(Tape_Num);

   localparam logic [AW-1:0] ADDR_CTRL = AW'(12'h000);
   localparam logic [AW-1:0] ADDR_LEN  = AW'(12'h010);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_WAIT_IN, S_MAC, S_OUT, S_DONE
   } state_t;

   state_t state_reg, state_next;

   logic           aw_ack_reg;
   logic           arready_reg;
   logic           rd_stage_reg;
   logic           rd_tap_reg;
   logic [DW-1:0]  rd_misc_reg;
   logic           rvalid_reg;
   logic [DW-1:0]  rdata_reg;
   logic           ap_done_reg;
   logic [DW-1:0]  len_reg;
   logic [3:0]     cnt_reg;
   logic [3:0]     ptr_reg;
   logic [3:0]     didx_reg;
   logic [DW-1:0]  acc_reg;
   logic [DW-1:0]  out_cnt_reg;

   logic           is_idle;
   logic           wr_fire;
   logic           wr_tap;
   logic           start_fire;
   logic           rd_tap_issue;
   logic           rd_busy;
   logic           arready_next;
   logic           mac_issue;
   logic           last_out;
   logic [DW-1:0]  prod;
   logic [DW-1:0]  ctrl_word;
   logic           unused_inputs;

   // The stream length is set by data_length alone; ss_tlast carries no control meaning.
   assign unused_inputs = ss_tlast;

   function automatic logic is_tap_addr(input logic [AW-1:0] a);
      return (a[1:0] == 2'b00) &&
             (a[AW-1:2] >= (AW-2)'(8)) &&
             (a[AW-1:2] <= (AW-2)'(8 + Tape_Num - 1));
   endfunction

   function automatic logic [AW-1:0] tap_byte_addr(input logic [AW-1:0] a);
      return a - AW'(32);
   endfunction

   function automatic logic [AW-1:0] word_addr(input logic [3:0] w);
      return {{(AW-6){1'b0}}, w, 2'b00};
   endfunction

   assign is_idle      = (state_reg == S_IDLE);
   assign wr_fire      = aw_ack_reg;
   assign wr_tap       = wr_fire && is_idle && is_tap_addr(awaddr);
   assign start_fire   = wr_fire && is_idle && (awaddr == ADDR_CTRL) && wdata[0];
   assign rd_tap_issue = arready_reg && is_idle && is_tap_addr(araddr);
   assign mac_issue    = (state_reg == S_MAC) && (cnt_reg <= LAST_IDX);
   assign last_out     = (out_cnt_reg + DW'(1)) >= len_reg;
   assign prod         = $signed(tap_Do) * $signed(data_Do);
   assign ctrl_word    = is_idle ? {{(DW-3){1'b0}}, 1'b1, ap_done_reg, 1'b0} : '0;

   // Host writes and host reads are kept mutually exclusive so the tap RAM port never collides.
   assign rd_busy      = arready_reg || rd_stage_reg || rvalid_reg;
   assign arready_next = arvalid && !rd_busy && !(awvalid && wvalid) && !aw_ack_reg;

   assign awready = aw_ack_reg;
   assign wready  = aw_ack_reg;
   assign arready = arready_reg;
   assign rvalid  = rvalid_reg;
   assign rdata   = rdata_reg;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) state_reg <= S_IDLE;
      else          state_reg <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:    if (start_fire)            state_next = S_CLEAR;
         S_CLEAR:   if (cnt_reg == LAST_IDX)   state_next = S_WAIT_IN;
         S_WAIT_IN: if (ss_tvalid)             state_next = S_MAC;
         S_MAC:     if (cnt_reg == MAC_END)    state_next = S_OUT;
         S_OUT:     if (sm_tready)             state_next = last_out ? S_DONE : S_WAIT_IN;
         S_DONE:                               state_next = S_IDLE;
         default:                              state_next = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs and RAM port steering ----------------
   always_comb begin
      ss_tready = (state_reg == S_WAIT_IN);
      sm_tvalid = (state_reg == S_OUT);
      sm_tdata  = (state_reg == S_OUT) ? acc_reg : '0;
      sm_tlast  = (state_reg == S_OUT) && last_out;

      tap_EN = 1'b0;
      tap_WE = 4'h0;
      tap_Di = '0;
      tap_A  = '0;
      if (mac_issue) begin
         tap_EN = 1'b1;
         tap_A  = word_addr(cnt_reg);
      end else if (wr_tap) begin
         tap_EN = 1'b1;
         tap_WE = 4'hf;
         tap_Di = wdata;
         tap_A  = tap_byte_addr(awaddr);
      end else if (rd_tap_issue) begin
         tap_EN = 1'b1;
         tap_A  = tap_byte_addr(araddr);
      end

      data_EN = 1'b0;
      data_WE = 4'h0;
      data_Di = '0;
      data_A  = '0;
      if (state_reg == S_CLEAR) begin
         data_EN = 1'b1;
         data_WE = 4'hf;
         data_A  = word_addr(cnt_reg);
      end else if (ss_tready && ss_tvalid) begin
         data_EN = 1'b1;
         data_WE = 4'hf;
         data_Di = ss_tdata;
         data_A  = word_addr(ptr_reg);
      end else if (mac_issue) begin
         data_EN = 1'b1;
         data_A  = word_addr(didx_reg);
      end
   end

   // ---------------- engine datapath ----------------
   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) begin
         cnt_reg     <= '0;
         ptr_reg     <= '0;
         didx_reg    <= '0;
         acc_reg     <= '0;
         out_cnt_reg <= '0;
      end else begin
         case (state_reg)
            S_IDLE: if (start_fire) begin
               cnt_reg     <= '0;
               ptr_reg     <= '0;
               out_cnt_reg <= '0;
            end
            S_CLEAR: cnt_reg <= cnt_reg + 4'd1;
            S_WAIT_IN: if (ss_tvalid) begin
               cnt_reg  <= '0;
               didx_reg <= ptr_reg;
               acc_reg  <= '0;
            end
            S_MAC: begin
               // Reads issued at cnt k return at k+1, so accumulation lags issue by one cycle.
               cnt_reg <= cnt_reg + 4'd1;
               if (cnt_reg <= LAST_IDX)
                  didx_reg <= (didx_reg == 4'd0) ? LAST_IDX : didx_reg - 4'd1;
               if (cnt_reg != 4'd0)
                  acc_reg <= acc_reg + prod;
            end
            S_OUT: if (sm_tready) begin
               out_cnt_reg <= out_cnt_reg + DW'(1);
               ptr_reg     <= (ptr_reg == LAST_IDX) ? 4'd0 : ptr_reg + 4'd1;
            end
            default: ;
         endcase
      end
   end

   // ---------------- control registers ----------------
   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) begin
         len_reg     <= '0;
         ap_done_reg <= 1'b0;
      end else begin
         if (wr_fire && is_idle && (awaddr == ADDR_LEN))
            len_reg <= wdata;
         if (state_reg == S_DONE)
            ap_done_reg <= 1'b1;
         else if (start_fire || (arready_reg && is_idle && (araddr == ADDR_CTRL)))
            ap_done_reg <= 1'b0;
      end
   end

   // ---------------- AXI4-Lite handshakes ----------------
   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) begin
         aw_ack_reg   <= 1'b0;
         arready_reg  <= 1'b0;
         rd_stage_reg <= 1'b0;
         rd_tap_reg   <= 1'b0;
         rd_misc_reg  <= '0;
         rvalid_reg   <= 1'b0;
         rdata_reg    <= '0;
      end else begin
         aw_ack_reg  <= awvalid && wvalid && !aw_ack_reg;
         arready_reg <= arready_next;
         if (arready_reg) begin
            rd_stage_reg <= 1'b1;
            rd_tap_reg   <= rd_tap_issue;
            if (araddr == ADDR_CTRL)     rd_misc_reg <= ctrl_word;
            else if (araddr == ADDR_LEN) rd_misc_reg <= len_reg;
            else                         rd_misc_reg <= '0;
         end else if (rd_stage_reg) begin
            rd_stage_reg <= 1'b0;
            rvalid_reg   <= 1'b1;
            rdata_reg    <= rd_tap_reg ? tap_Do : rd_misc_reg;
         end else if (rvalid_reg && rready) begin
            rvalid_reg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fir_axi_filter.sv
// Directed bench for fir_axi_filter: models both registered-read RAMs, drives the
// AXI-Lite and stream ports, and checks outputs against hand-computed and modelled values.
module tb_fir_axi_filter;

   logic        axis_clk = 1'b0;
   logic        axis_rst = 1'b1;
   logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, arready, rvalid;
   logic [11:0] awaddr = '0, araddr = '0;
   logic [31:0] wdata = '0, rdata;
   logic        ss_tvalid = 1'b0, ss_tlast = 1'b0, ss_tready;
   logic [31:0] ss_tdata = '0;
   logic        sm_tvalid, sm_tlast, sm_tready = 1'b0;
   logic [31:0] sm_tdata;
   logic [3:0]  tap_WE, data_WE;
   logic        tap_EN, data_EN;
   logic [31:0] tap_Di, data_Di, tap_Do, data_Do;
   logic [11:0] tap_A, data_A;

   int taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
   int imp_exp [14] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0, 0, 0, 0};
   int step_exp [13] = '{0, -10, -19, 4, 60, 123, 179, 202, 193, 183, 183, 183, 183};
   int x_buf [600];
   int exp_buf [600];
   int n_chk = 0;
   int n_pass = 0;

   always #5 axis_clk = ~axis_clk;

   fir_axi_filter dut (
      .axis_clk(axis_clk), .axis_rst(axis_rst),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata),
      .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
      .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
      .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
      .data_WE(data_WE), .data_EN(data_EN), .data_Di(data_Di), .data_A(data_A), .data_Do(data_Do)
   );

   // Two 11 x 32 single-port RAMs with one-cycle registered read.
   logic [31:0] tap_mem [0:10];
   logic [31:0] data_mem [0:10];
   logic [3:0]  tap_wi, data_wi;
   logic        tap_ok, data_ok;
   assign tap_wi  = tap_A[5:2];
   assign data_wi = data_A[5:2];
   assign tap_ok  = (tap_A[11:6] == 6'd0) && (tap_A[1:0] == 2'd0) && (tap_wi < 4'd11);
   assign data_ok = (data_A[11:6] == 6'd0) && (data_A[1:0] == 2'd0) && (data_wi < 4'd11);

   always @(posedge axis_clk) begin
      if (tap_EN && tap_ok) begin
         for (int b = 0; b < 4; b++)
            if (tap_WE[b]) tap_mem[tap_wi][8*b +: 8] <= tap_Di[8*b +: 8];
         tap_Do <= tap_mem[tap_wi];
      end
   end

   always @(posedge axis_clk) begin
      if (data_EN && data_ok) begin
         for (int b = 0; b < 4; b++)
            if (data_WE[b]) data_mem[data_wi][8*b +: 8] <= data_Di[8*b +: 8];
         data_Do <= data_mem[data_wi];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
   endtask

   task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
      bit ok;
      ok = 1'b0;
      awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge axis_clk);
         if (awready && wready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("awready_timeout", 32'(ok), 32'd1);
      @(posedge axis_clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic axil_read(input logic [11:0] a, output logic [31:0] d);
      bit ok;
      ok = 1'b0;
      d = 32'hx;
      araddr = a; arvalid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge axis_clk);
         if (arready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("arready_timeout", 32'(ok), 32'd1);
      @(posedge axis_clk); #1;
      arvalid = 1'b0; rready = 1'b1; ok = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge axis_clk);
         if (rvalid) begin ok = 1'b1; d = rdata; break; end
      end
      if (!ok) chk("rvalid_timeout", 32'(ok), 32'd1);
      @(posedge axis_clk); #1;
      rready = 1'b0;
   endtask

   task automatic feed(input int v);
      bit ok;
      ok = 1'b0;
      ss_tdata = v; ss_tvalid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge axis_clk);
         if (ss_tready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("ss_tready_timeout", 32'(ok), 32'd1);
      @(posedge axis_clk); #1;
      ss_tvalid = 1'b0; ss_tdata = '0;
   endtask

   task automatic collect(input string tag, input int exp_y, input bit exp_last);
      bit ok;
      ok = 1'b0;
      sm_tready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge axis_clk);
         if (sm_tvalid) begin ok = 1'b1; break; end
      end
      if (!ok) chk({tag, "_timeout"}, 32'(ok), 32'd1);
      chk({tag, "_y"}, sm_tdata, exp_y);
      chk({tag, "_last"}, 32'(sm_tlast), 32'(exp_last));
      @(posedge axis_clk); #1;
      sm_tready = 1'b0;
   endtask

   // Starts a run and streams x_buf[0..n-1]; optionally probes status mid-run.
   task automatic run_stream(input string name, input int n, input int mid);
      logic [31:0] r;
      axil_write(12'h010, 32'(n));
      axil_write(12'h000, 32'd1);
      for (int i = 0; i < n; i++) begin
         feed(x_buf[i]);
         if (i == mid) begin
            axil_read(12'h000, r);
            chk({name, "_mid_ctrl"}, r & 32'hf, 32'd0);
            axil_read(12'h034, r);
            chk({name, "_mid_tap5"}, r, 32'd0);
         end
         collect($sformatf("%s_%0d", name, i), exp_buf[i], i == n - 1);
      end
   endtask

   task automatic load_impulse();
      for (int i = 0; i < 14; i++) begin
         x_buf[i] = (i == 0) ? 1 : 0;
         exp_buf[i] = imp_exp[i];
      end
   endtask

   initial begin
      logic [31:0] r;
      bit held;

      repeat (3) @(posedge axis_clk);
      #1;
      chk("rst_ss_tready", 32'(ss_tready), 32'd0);
      chk("rst_sm_tvalid", 32'(sm_tvalid), 32'd0);
      chk("rst_awready", 32'(awready), 32'd0);
      axis_rst = 1'b0;
      @(posedge axis_clk); #1;

      axil_read(12'h000, r);  chk("rst_ctrl", r, 32'h4);
      axil_read(12'h010, r);  chk("rst_len", r, 32'd0);

      // Program length and taps, read everything back
      axil_write(12'h010, 32'd600);
      for (int k = 0; k < 11; k++) axil_write(12'(32 + 4 * k), 32'(taps[k]));
      axil_write(12'h050, 32'h1234_5678);
      for (int k = 0; k < 11; k++) begin
         axil_read(12'(32 + 4 * k), r);
         chk($sformatf("tap%0d", k), r, 32'(taps[k]));
      end
      axil_read(12'h010, r);  chk("len600", r, 32'd600);
      axil_read(12'h050, r);  chk("unmapped", r, 32'd0);
      axil_read(12'h000, r);  chk("idle_ctrl", r, 32'h4);

      // Impulse, step, impulse again: history must not leak between runs
      load_impulse();
      run_stream("imp", 14, -1);
      for (int i = 0; i < 13; i++) begin
         x_buf[i] = 1;
         exp_buf[i] = step_exp[i];
      end
      run_stream("step", 13, -1);
      load_impulse();
      run_stream("imp2", 14, -1);

      // 600-sample triangle wave against a direct convolution model
      for (int n = 0; n < 600; n++) begin
         x_buf[n] = ((n % 40) < 20) ? (n % 40) * 5 - 50 : (40 - n % 40) * 5 - 50;
         exp_buf[n] = 0;
         for (int i = 0; i < 11; i++)
            if (n - i >= 0) exp_buf[n] += taps[i] * x_buf[n - i];
      end
      run_stream("tri", 600, 300);
      held = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge axis_clk);
         if (ss_tready) held = 1'b0;
      end
      chk("done_ss_tready_low", 32'(held), 32'd1);
      axil_read(12'h000, r);  chk("done_ctrl", r, 32'h6);
      axil_read(12'h000, r);  chk("done_clear_on_read", r, 32'h4);

      // Reset in the middle of a run
      axil_write(12'h010, 32'd600);
      axil_write(12'h000, 32'd1);
      for (int i = 0; i < 4; i++) begin
         feed(x_buf[i]);
         collect($sformatf("pre_rst_%0d", i), exp_buf[i], 1'b0);
      end
      feed(x_buf[4]);
      repeat (3) @(posedge axis_clk);
      @(negedge axis_clk);
      axis_rst = 1'b1;
      #1;
      chk("midrst_ss_tready", 32'(ss_tready), 32'd0);
      chk("midrst_sm_tvalid", 32'(sm_tvalid), 32'd0);
      @(posedge axis_clk); #1;
      axis_rst = 1'b0;
      @(posedge axis_clk); #1;
      axil_read(12'h000, r);  chk("midrst_ctrl", r, 32'h4);
      axil_read(12'h010, r);  chk("midrst_len", r, 32'd0);
      axil_read(12'h02c, r);  chk("midrst_tap3", r, 32'(taps[3]));

      load_impulse();
      run_stream("imp3", 14, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
